// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential Booth multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// MUL_N   : default operand width (product is 2*MUL_N bits).
// STEPS   : Booth steps per operation; operands carry one extra bit so
//           signed and unsigned inputs share one datapath.
// CNT_W   : width of a counter that can hold 0..STEPS.
package mul_pkg;

    localparam int MUL_N = 32;
    localparam int STEPS = MUL_N + 1;
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_r2_step.sv
// One radix-2 Booth step: conditional add/subtract of Xext, then arithmetic shift of {A,M,q}.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the outputs.
//
// Ports:
//   A      (N+2) accumulator; the extra top bit keeps add/sub from overflowing
//   M      (N+1) multiplier register (low product bits shift in from the top)
//   q             Booth history bit
//   Xext   (N+1) extended multiplicand
//   A_next, M_next, q_next : register values after this step
module booth_r2_step #(
    parameter int N = 32
) (
    input  logic [N+1:0] A,
    input  logic [N:0]   M,
    input  logic         q,
    input  logic [N:0]   Xext,
    output logic [N+1:0] A_next,
    output logic [N:0]   M_next,
    output logic         q_next
);

    logic [N+1:0] x_se;
    logic [N+1:0] sum;

    assign x_se = {Xext[N], Xext};

    always_comb begin
        sum = A;
        case ({M[0], q})
            2'b01:   sum = A + x_se;
            2'b10:   sum = A - x_se;
            default: sum = A;
        endcase
    end

    // Arithmetic right shift of the combined {sum, M, q} register.
    assign A_next = {sum[N+1], sum[N+1:1]};
    assign M_next = {sum[0], M[N:1]};
    assign q_next = M[0];

endmodule

// File: rtl/mul_32b_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned, full 2N-bit product plus overflow flag.
// Latency: accept at E0, out_valid pulses for one cycle after E(N+1) (N+1 cycles).
// Backpressure: none; in_valid is ignored while busy, nothing is queued.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   X, Y            multiplicand / multiplier (captured only at accept)
//   is_signed       1 = two's complement operands, 0 = unsigned
//   in_valid        start request, honoured only in IDLE
//   P, ovf          registered product and truncation-overflow flag (held until next result)
//   out_valid       one-cycle result pulse
//   busy            high from accept through the out_valid cycle
module mul_32b_seq
    import mul_pkg::*;
#(
    parameter int N = MUL_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   X,
    input  logic [N-1:0]   Y,
    input  logic           is_signed,
    input  logic           in_valid,
    output logic [2*N-1:0] P,
    output logic           ovf,
    output logic           out_valid,
    output logic           busy
);

    localparam int N_STEPS  = N + 1;
    localparam int CNT_BITS = $clog2(N_STEPS + 1);

    state_t              state;
    state_t              state_nx;
    logic [N+1:0]        acc;
    logic [N:0]          mreg;
    logic                qbit;
    logic [N:0]          xext;
    logic                sgn;
    logic [CNT_BITS-1:0] cnt;

    logic [N+1:0]        acc_nx;
    logic [N:0]          m_nx;
    logic                q_nx;
    logic                last_step;
    logic [2*N-1:0]      prod;
    logic                ovf_nx;

    booth_r2_step #(.N(N)) u_step (
        .A      (acc),
        .M      (mreg),
        .q      (qbit),
        .Xext   (xext),
        .A_next (acc_nx),
        .M_next (m_nx),
        .q_next (q_nx)
    );

    assign last_step = (cnt == CNT_BITS'(N_STEPS - 1));

    // Low 2N bits of {A,M} after the final shift: all of M plus A[N-2:0].
    assign prod = {acc_nx[N-2:0], m_nx};

    // Overflow means the upper half is not a pure extension of the lower half.
    assign ovf_nx = sgn ? (prod[2*N-1:N] != {N{prod[N-1]}})
                        : (prod[2*N-1:N] != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = CALC;
            CALC:    if (last_step) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            mreg <= '0;
            qbit <= 1'b0;
            xext <= '0;
            sgn  <= 1'b0;
            cnt  <= '0;
            P    <= '0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xext <= is_signed ? {X[N-1], X} : {1'b0, X};
                        mreg <= is_signed ? {Y[N-1], Y} : {1'b0, Y};
                        sgn  <= is_signed;
                        acc  <= '0;
                        qbit <= 1'b0;
                        cnt  <= '0;
                    end
                end
                CALC: begin
                    acc  <= acc_nx;
                    mreg <= m_nx;
                    qbit <= q_nx;
                    cnt  <= cnt + CNT_BITS'(1);
                    if (last_step) begin
                        P   <= prod;
                        ovf <= ovf_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_32b_seq.sv
// Self-checking bench for mul_32b_seq: directed cases, busy/reset handling, divider round trip.
// Latency: expects out_valid 33 cycles after the accepting edge.
// Backpressure: stimulus waits for busy=0 before each request.
module tb_mul_32b_seq;

    logic        clk;
    logic        rst;
    logic [31:0] X;
    logic [31:0] Y;
    logic        is_signed;
    logic        in_valid;
    logic [63:0] P;
    logic        ovf;
    logic        out_valid;
    logic        busy;

    int          n_tests;
    int          n_fail;
    int          cyc;
    logic [63:0] last_p;

    typedef struct {
        logic [63:0] p;
        logic        ovf;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];

    mul_32b_seq dut (
        .clk       (clk),
        .rst       (rst),
        .X         (X),
        .Y         (Y),
        .is_signed (is_signed),
        .in_valid  (in_valid),
        .P         (P),
        .ovf       (ovf),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Result monitor: every out_valid pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (sb.size() == 0) begin
                check("stray_out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", P, e.p);
                check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
                check("latency", 64'(cyc - e.acc_cyc), 64'd33);
            end
            last_p = P;
        end
    end

    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                            input bit push, input logic [63:0] ep, input logic eo);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_wait_timeout", 64'd1, 64'd0);
        X         = x;
        Y         = y;
        is_signed = s;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        // Scramble operands: they must have been captured at the accept edge.
        X         = $urandom;
        Y         = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        check("busy_on_accept", {63'd0, busy}, 64'd1);
        check("p_hold", P, last_p);
        if (push) sb.push_back('{p: ep, ovf: eo, acc_cyc: cyc});
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 60);
        if (!out_valid) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check("busy_fall", {63'd0, busy}, 64'd0);
        check("out_valid_pulse", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [63:0] ep, input logic eo);
        start_op(x, y, s, 1'b1, ep, eo);
        wait_done();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx, ry, rq, rr;
        n_tests   = 0;
        n_fail    = 0;
        last_p    = 64'd0;
        rst       = 1'b0;
        X         = '0;
        Y         = '0;
        is_signed = 1'b0;
        in_valid  = 1'b0;

        #12;
        check("rst_P", P, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed products.
        run_op(32'd5,        32'd2,        1'b0, 64'h000000000000000A, 1'b0);
        run_op(32'hFFFFFFFD, 32'd7,        1'b1, 64'hFFFFFFFFFFFFFFEB, 1'b0);
        run_op(32'hFFFFFFFD, 32'd7,        1'b0, 64'h00000006FFFFFFEB, 1'b1);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
        run_op(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1);
        run_op(32'h80000000, 32'd1,        1'b1, 64'hFFFFFFFF80000000, 1'b0);

        // A request arriving mid-operation is dropped.
        start_op(32'd6, 32'd7, 1'b0, 1'b1, 64'd42, 1'b0);
        repeat (9) @(negedge clk);
        X        = 32'd9;
        Y        = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_during_calc", {63'd0, busy}, 64'd1);
        wait_done();
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-operation discards the partial result.
        start_op(32'd6, 32'd7, 1'b0, 1'b0, 64'd0, 1'b0);
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_P", P, 64'd0);
        check("arst_ovf", {63'd0, ovf}, 64'd0);
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        last_p = 64'd0;
        @(negedge clk);
        rst = 1'b1;
        run_op(32'd3, 32'd4, 1'b0, 64'd12, 1'b0);
        repeat (40) @(negedge clk);

        // Divider round trip: Q*Y + R must reproduce X, so P must equal X - R.
        for (int i = 0; i < 300; i++) begin
            rx = $urandom;
            ry = $urandom >> $urandom_range(0, 31);
            if (ry == 32'd0) ry = 32'd1;
            rq = rx / ry;
            rr = rx % ry;
            run_op(rq, ry, 1'b0, {32'd0, rx} - {32'd0, rr}, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
